// File: rtl/axis_mux2.sv
// axis_mux2: 2:1 AXI4-Stream multiplexer with a registered output stage.
// One-cycle latency, one beat per cycle when the consumer is always ready.
// Optional feature macro: AXIS_MUX_PKT_LOCK_EN.
//   Defined   : once a beat with TLAST=0 is accepted, the routed channel is
//               locked until that channel's TLAST beat is accepted, so
//               packets from the two channels never interleave.
//   Undefined : no lock; every beat is routed by sel.
//
// Handshake (valid/ready): a beat moves across an interface on a rising
// edge where valid and ready are both 1. A producer holds valid, data and
// last stable until that happens; ready may depend combinationally on the
// consumer's ready, but valid never depends on ready. TREADY_in applies
// only to the currently routed channel; the other channel sees it as 0.
module axis_mux2 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [DATA_WIDTH-1:0] DATA_in_0,
  input  logic                  TVALID_in_0,
  input  logic                  TLAST_in_0,
  input  logic [DATA_WIDTH-1:0] DATA_in_1,
  input  logic                  TVALID_in_1,
  input  logic                  TLAST_in_1,
  input  logic                  sel,
  output logic                  TREADY_in,
  output logic [DATA_WIDTH-1:0] DATA_out,
  output logic                  TVALID_out,
  output logic                  TLAST_out,
  input  logic                  TREADY_out
);

  // Output register and packet-lock state.
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  in_pkt_q, in_pkt_d;
  logic                  locked_ch_q, locked_ch_d;

  // Routed-channel view.
  logic                  route_ch;
  logic                  route_valid;
  logic                  route_last;
  logic [DATA_WIDTH-1:0] route_data;
  logic                  accept;
  logic                  fire;

  // Pick the routed channel: the locked one mid-packet, otherwise sel.
  always_comb begin
    route_ch    = in_pkt_q ? locked_ch_q : sel;
    route_valid = TVALID_in_0;
    route_last  = TLAST_in_0;
    route_data  = DATA_in_0;
    if (route_ch) begin
      route_valid = TVALID_in_1;
      route_last  = TLAST_in_1;
      route_data  = DATA_in_1;
    end
  end

  // The register can take a new beat when empty or when it drains this cycle.
  assign TREADY_in = !ARESET && (!tvalid_q || TREADY_out);
  assign accept    = route_valid && TREADY_in;
  assign fire      = tvalid_q && TREADY_out;

  // Next-state for the output register and the packet lock.
  always_comb begin
    data_d      = data_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    in_pkt_d    = in_pkt_q;
    locked_ch_d = locked_ch_q;

    if (accept) begin
      data_d   = route_data;
      tlast_d  = route_last;
      tvalid_d = 1'b1;
    end else if (fire) begin
      tvalid_d = 1'b0;
    end

`ifdef AXIS_MUX_PKT_LOCK_EN
    if (accept) begin
      if (route_last) begin
        in_pkt_d = 1'b0;
      end else begin
        in_pkt_d    = 1'b1;
        locked_ch_d = route_ch;
      end
    end
`else
    in_pkt_d    = 1'b0;
    locked_ch_d = 1'b0;
`endif
  end

  // State registers; reset discards any held beat and clears the lock.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      data_q      <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      in_pkt_q    <= 1'b0;
      locked_ch_q <= 1'b0;
    end else begin
      data_q      <= data_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      in_pkt_q    <= in_pkt_d;
      locked_ch_q <= locked_ch_d;
    end
  end

  assign DATA_out   = data_q;
  assign TVALID_out = tvalid_q;
  assign TLAST_out  = tlast_q;

endmodule

// File: tb/tb_axis_mux2.sv
// Testbench for axis_mux2: directed steps from the test plan followed by a
// randomized phase, all checked against a queue-based reference model.
module tb_axis_mux2;

  localparam int W = 8;

  // Clock / reset
  logic         clk = 1'b0;
  logic         areset;
  always #5 clk = ~clk;

  // DUT connections
  logic [W-1:0] data0, data1;
  logic         tvalid0, tvalid1, tlast0, tlast1, sel;
  logic         tready_in;
  logic [W-1:0] data_out;
  logic         tvalid_out, tlast_out;
  logic         tready_out;

  axis_mux2 #(.DATA_WIDTH(W)) dut (
    .ACLK       (clk),
    .ARESET     (areset),
    .DATA_in_0  (data0),
    .TVALID_in_0(tvalid0),
    .TLAST_in_0 (tlast0),
    .DATA_in_1  (data1),
    .TVALID_in_1(tvalid1),
    .TLAST_in_1 (tlast1),
    .sel        (sel),
    .TREADY_in  (tready_in),
    .DATA_out   (data_out),
    .TVALID_out (tvalid_out),
    .TLAST_out  (tlast_out),
    .TREADY_out (tready_out)
  );

  // Reference model: the output stage is a one-deep queue of {last,data};
  // lock_owner is the channel owning an open packet, -1 when none.
  logic [W:0]   exp_q[$];
  int           lock_owner = -1;
  logic         acc0, acc1;
  logic [W-1:0] obs_log[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check ready before the edge, advance the model across
  // the edge, then check the registered outputs.
  task automatic cycle();
    logic exp_ready, fire, r, rv;
    logic [W:0] beat;
    @(negedge clk);
    exp_ready = !areset && (exp_q.size() == 0 || tready_out);
    check("tready_in", {31'd0, tready_in}, {31'd0, exp_ready});
    r    = (lock_owner >= 0) ? lock_owner[0] : sel;
    rv   = r ? tvalid1 : tvalid0;
    beat = r ? {tlast1, data1} : {tlast0, data0};
    fire = (exp_q.size() != 0) && tready_out;
    acc0 = exp_ready && rv && !r;
    acc1 = exp_ready && rv && r;
    if (tvalid_out === 1'b1 && tready_out) obs_log.push_back(data_out);
    @(posedge clk);
    #1;
    if (areset) begin
      exp_q.delete();
      lock_owner = -1;
    end else begin
      if (fire) void'(exp_q.pop_front());
      if (acc0 || acc1) begin
        exp_q.push_back(beat);
`ifdef AXIS_MUX_PKT_LOCK_EN
        lock_owner = beat[W] ? -1 : int'(r);
`endif
      end
    end
    check("tvalid_out", {31'd0, tvalid_out}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      check("data_out", {24'd0, data_out}, {24'd0, exp_q[0][W-1:0]});
      check("tlast_out", {31'd0, tlast_out}, {31'd0, exp_q[0][W]});
    end
  endtask

  // Expected output order of the packet-lock step.
  logic [W-1:0] pkt_exp[$];

  initial begin
    int n0;
    int guard;
    logic sel_done;

    // Reset with channel 0 already presenting a beat.
    areset = 1'b1; sel = 1'b0; tready_out = 1'b1;
    tvalid0 = 1'b1; data0 = 8'h55; tlast0 = 1'b1;
    tvalid1 = 1'b0; data1 = 8'h00; tlast1 = 1'b0;
    cycle();
    cycle();
    check("rst_data", {24'd0, data_out}, 32'h0);
    check("rst_last", {31'd0, tlast_out}, 32'h0);
    check("rst_valid", {31'd0, tvalid_out}, 32'h0);
    areset = 1'b0; tvalid0 = 1'b0;
    cycle();

    // Channel 0 streaming.
    sel = 1'b0; tvalid0 = 1'b1; data0 = 8'h12; tlast0 = 1'b0;
    cycle();
    check("ch0_first", {24'd0, data_out}, 32'h12);
    data0 = 8'h34; tlast0 = 1'b1;
    cycle();
    check("ch0_second", {24'd0, data_out}, 32'h34);
    check("ch0_valid", {31'd0, tvalid_out}, 32'h1);
    tvalid0 = 1'b0;
    cycle();

    // Backpressure on channel 1.
    sel = 1'b1; tvalid1 = 1'b1; data1 = 8'h40; tlast1 = 1'b1;
    cycle();
    data1 = 8'h41; tready_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_hold", {24'd0, data_out}, 32'h40);
      check("bp_ready", {31'd0, tready_in}, 32'h0);
    end
    tready_out = 1'b1;
    cycle();
    check("bp_reload", {24'd0, data_out}, 32'h41);
    tvalid1 = 1'b0;
    cycle();

    // Both channels valid, sel picks channel 1; channel 0 waits intact.
    tvalid0 = 1'b1; data0 = 8'hAA; tlast0 = 1'b1;
    tvalid1 = 1'b1; data1 = 8'hBB; tlast1 = 1'b1; sel = 1'b1;
    cycle();
    check("both_sel1", {24'd0, data_out}, 32'hBB);
    check("both_no_acc0", {31'd0, acc0}, 32'h0);
    tvalid1 = 1'b0; sel = 1'b0;
    cycle();
    check("both_ch0_later", {24'd0, data_out}, 32'hAA);
    tvalid0 = 1'b0;
    cycle();

    // 8-beat packet on channel 0, sel flips to 1 after beat 2.
    obs_log.delete();
    n0 = 0; sel_done = 1'b0;
    sel = 1'b0; tvalid0 = 1'b1; data0 = 8'h80; tlast0 = 1'b0;
`ifdef AXIS_MUX_PKT_LOCK_EN
    for (int i = 0; i < 8; i++) pkt_exp.push_back(8'h80 + W'(i));
    pkt_exp.push_back(8'hC0);
`else
    pkt_exp.push_back(8'h80); pkt_exp.push_back(8'h81); pkt_exp.push_back(8'hC0);
    for (int i = 2; i < 8; i++) pkt_exp.push_back(8'h80 + W'(i));
`endif
    for (int c = 0; c < 14; c++) begin
      cycle();
      if (acc0) begin
        n0++;
        if (n0 < 8) begin
          data0 = 8'h80 + W'(n0); tlast0 = (n0 == 7);
        end else begin
          tvalid0 = 1'b0;
        end
        if (n0 == 2 && !sel_done) begin
          sel = 1'b1; sel_done = 1'b1;
          tvalid1 = 1'b1; data1 = 8'hC0; tlast1 = 1'b1;
        end
      end
      if (acc1) begin
        tvalid1 = 1'b0; sel = 1'b0;
      end
    end
    check("pkt_count", obs_log.size(), pkt_exp.size());
    for (int i = 0; i < pkt_exp.size(); i++) begin
      if (i < obs_log.size()) check("pkt_order", {24'd0, obs_log[i]}, {24'd0, pkt_exp[i]});
    end

    // Reset in the middle of a packet.
    n0 = 0; guard = 0;
    sel = 1'b0; tvalid0 = 1'b1; data0 = 8'h90; tlast0 = 1'b0;
    while (n0 < 4 && guard < 20) begin
      cycle();
      guard++;
      if (acc0) begin
        n0++;
        data0 = 8'h90 + W'(n0);
      end
    end
    check("midpkt_beats", n0, 4);
    areset = 1'b1;
    cycle();
    check("midpkt_rst_valid", {31'd0, tvalid_out}, 32'h0);
    check("midpkt_rst_data", {24'd0, data_out}, 32'h0);
    areset = 1'b0; sel = 1'b1;
    tvalid1 = 1'b1; data1 = 8'hE1; tlast1 = 1'b1;
    cycle();
    check("midpkt_ch1", {24'd0, data_out}, 32'hE1);
    check("midpkt_ch1_valid", {31'd0, tvalid_out}, 32'h1);
    tvalid0 = 1'b0; tvalid1 = 1'b0; sel = 1'b0;
    cycle();

    // Randomized traffic; sources hold their beat until it is accepted.
    for (int c = 0; c < 800; c++) begin
      sel        = 1'($urandom_range(0, 1));
      tready_out = ($urandom_range(0, 3) != 0);
      areset     = ($urandom_range(0, 99) == 0);
      cycle();
      if (acc0 || !tvalid0) begin
        tvalid0 = ($urandom_range(0, 3) != 0);
        data0   = W'($urandom);
        tlast0  = ($urandom_range(0, 3) == 0);
      end
      if (acc1 || !tvalid1) begin
        tvalid1 = ($urandom_range(0, 3) != 0);
        data1   = W'($urandom);
        tlast1  = ($urandom_range(0, 3) == 0);
      end
    end
    areset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_mux2.md
Name: axis_mux2

Overview:
- 2:1 AXI4-Stream multiplexer with a registered output stage.
- Routes one of two upstream streams (channel 0 / channel 1) to a single downstream stream, chosen by `sel`.
- Optional packet locking keeps a packet contiguous.
- Sits between two stream producers and one consumer; one-cycle latency, full throughput.

Parameters:
- DATA_WIDTH, 8, width of the data buses DATA_in_0, DATA_in_1 and DATA_out.

Ports:
- ACLK  input  1  clock; all logic on the rising edge.
- ARESET  input  1  reset; synchronous, active-high.
- DATA_in_0  input  DATA_WIDTH  channel 0 data.
- TVALID_in_0  input  1  channel 0 valid.
- TLAST_in_0  input  1  channel 0 end-of-packet.
- DATA_in_1  input  DATA_WIDTH  channel 1 data.
- TVALID_in_1  input  1  channel 1 valid.
- TLAST_in_1  input  1  channel 1 end-of-packet.
- sel  input  1  requested channel: 0 selects channel 0, 1 selects channel 1.
- TREADY_in  output  1  ready to upstream; qualifies only the currently routed channel.
- DATA_out  output  DATA_WIDTH  downstream data (registered).
- TVALID_out  output  1  downstream valid (registered).
- TLAST_out  output  1  downstream last (registered).
- TREADY_out  input  1  downstream ready.

Behaviour:
- **Reset** (ARESET=1 at a rising edge):
  - DATA_out=0, TVALID_out=0, TLAST_out=0.
  - Internal lock state cleared: in_pkt=0, locked_ch=0.
  - TREADY_in=0 while ARESET=1.
  - A beat held at the output is discarded, including mid-packet.
- **Routed channel r:**
  - If packet lock is active (in_pkt=1), r=locked_ch.
  - Otherwise r=sel.
- **Ready:** TREADY_in = !ARESET && (!TVALID_out || TREADY_out). This is combinational from registered state and TREADY_out.
- **Accept:** at a rising edge with TVALID_in_r=1 and TREADY_in=1, the beat is accepted. On the next cycle:
  - DATA_out=DATA_in_r
  - TLAST_out=TLAST_in_r
  - TVALID_out=1
- **Non-routed channel:** never accepted. Its upstream must treat TREADY_in as 0 and hold its beat.
- **Output fire:** TVALID_out && TREADY_out.
  - If it fires with no new accept, TVALID_out clears next cycle.
  - Fire and accept in the same cycle: the register reloads with no bubble.
- **Stall:** while TVALID_out=1 and TREADY_out=0, DATA_out/TLAST_out/TVALID_out are held stable. TREADY_in=0 in this state.
- **Timing:** latency 1 cycle input-to-output. Sustained throughput 1 beat/cycle while TREADY_out=1.
- **Simultaneous valids:** sel (or locked_ch) decides; the other channel stalls with no data loss.
- **sel changes:** sel may change on any cycle. It affects only beats accepted after the change, subject to packet lock.
- **TVALID_in_r=0:** no accept; the output register drains normally.

Optional Feature:
- Macro: AXIS_MUX_PKT_LOCK_EN.
- **Defined:**
  - On accept with TLAST_in_r=0: in_pkt=1 and locked_ch=r.
  - On accept with TLAST_in_r=1: in_pkt=0.
  - While in_pkt=1, sel is ignored, so packets are never interleaved.
- **Undefined:** in_pkt is tied to 0 and r=sel on every beat. Beats from both channels may interleave arbitrarily.

Test Plan:
- **Reset:** ARESET=1 for 2 cycles with TVALID_in_0=1 -> TVALID_out=0, DATA_out=0, TLAST_out=0, TREADY_in=0. Release -> TREADY_in=1 next cycle.
- **Channel 0 streaming:** sel=0, TVALID_in_0=1, DATA_in_0=0x12 then 0x34, TREADY_out=1 -> DATA_out 0x12 then 0x34 one cycle later; TVALID_out=1 each cycle.
- **Backpressure:** sel=1, TVALID_in_1=1, DATA_in_1=0x40, TREADY_out=0 for 3 cycles -> DATA_out stays 0x40, TVALID_out=1, TREADY_in=0. TREADY_out=1 -> beat fires; the next input is accepted in the same cycle.
- **Both valid:** TVALID_in_0=TVALID_in_1=1, DATA_in_0=0xAA, DATA_in_1=0xBB, sel=1 -> DATA_out=0xBB; channel 0 is not accepted.
- **Packet lock (AXIS_MUX_PKT_LOCK_EN):**
  - Channel 0 sends an 8-beat packet with TLAST on beat 8; sel toggles to 1 after beat 2.
  - Required: all 8 channel-0 beats go out contiguously with TLAST_out=1 on beat 8.
  - The next beat comes from channel 1.
  - Without the macro, channel 1 beats appear immediately after beat 2.
- **Reset mid-packet:** ARESET asserted during beat 4 of a locked packet -> output cleared, lock cleared. After release, sel=1 selects channel 1 immediately.
